// File: rtl/inst_rom_arbiter_pkg.sv
// Shared definitions for the instruction ROM arbiter: FSM encodings, port indices
// and default bus widths.
package inst_rom_arbiter_pkg;

   localparam int INST_ADDR_BUS_W = 32;
   localparam int INST_BUS_W      = 32;

   localparam logic ARB_PORT_CPU = 1'b0;
   localparam logic ARB_PORT_DBG = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   function automatic logic addr_misaligned(input logic [1:0] i_lsb);
      return |i_lsb;
   endfunction

endpackage

// File: rtl/inst_rom_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: combinational winner from the current requests,
// last_grant register advanced whenever a grant is taken.
module rr_arbiter2
   import inst_rom_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_en,
   output logic       o_win,
   output logic       o_any
);

   logic r_last_grant;

   always_comb begin
      o_any = |i_req;
      if (&i_req)
         o_win = ~r_last_grant;
      else
         o_win = i_req[1];
   end

   // Reset to the debug port so the CPU wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_last_grant <= ARB_PORT_DBG;
      else if (i_en && o_any)
         r_last_grant <= o_win;
   end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the single-port instruction ROM between CPU fetch (port 0) and debug (port 1).
// Optional alignment check enabled by ROM_ARB_ALIGN_CHECK_EN (adds err_o).
//
// state      | meaning
// ARB_IDLE   | no access in flight, arbitrate on any request
// ARB_ACCESS | rom_ce_o held ROM_LATENCY cycles, then sample rom_data_i
// ARB_RESP   | rvalid pulse for the served port, arbitrate for back-to-back service
module inst_rom_arbiter
   import inst_rom_arbiter_pkg::*;
#(
   parameter int ADDR_W      = INST_ADDR_BUS_W,
   parameter int DATA_W      = INST_BUS_W,
   parameter int ROM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   output logic              gnt0_o,
   output logic              rvalid0_o,
   input  logic              req1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   output logic              gnt1_o,
   output logic              rvalid1_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
`ifdef ROM_ARB_ALIGN_CHECK_EN
   output logic              err_o,
`endif
   output logic              busy_o
);

   localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LATENCY - 1);

   arb_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sel;

   logic              w_arb_en;
   logic              w_win;
   logic              w_any;
   logic [ADDR_W-1:0] w_addr;
   logic              w_ce_on_grant;

   assign w_arb_en = (r_state == ARB_IDLE) || (r_state == ARB_RESP);
   assign w_addr   = w_win ? addr1_i : addr0_i;

`ifdef ROM_ARB_ALIGN_CHECK_EN
   logic r_misal;
   logic w_misal;
   assign w_misal       = addr_misaligned(w_addr[1:0]);
   assign w_ce_on_grant = ~w_misal;
`else
   assign w_ce_on_grant = 1'b1;
`endif

   rr_arbiter2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .i_req ({req1_i, req0_i}),
      .i_en  (w_arb_en),
      .o_win (w_win),
      .o_any (w_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_cnt      <= '0;
         r_sel      <= ARB_PORT_CPU;
         gnt0_o     <= 1'b0;
         gnt1_o     <= 1'b0;
         rvalid0_o  <= 1'b0;
         rvalid1_o  <= 1'b0;
         rdata_o    <= '0;
         rom_ce_o   <= 1'b0;
         rom_addr_o <= '0;
         busy_o     <= 1'b0;
`ifdef ROM_ARB_ALIGN_CHECK_EN
         r_misal    <= 1'b0;
         err_o      <= 1'b0;
`endif
      end else begin
         gnt0_o    <= 1'b0;
         gnt1_o    <= 1'b0;
         rvalid0_o <= 1'b0;
         rvalid1_o <= 1'b0;
`ifdef ROM_ARB_ALIGN_CHECK_EN
         err_o     <= 1'b0;
`endif
         case (r_state)
            ARB_IDLE, ARB_RESP: begin
               if (w_any) begin
                  r_sel      <= w_win;
                  rom_addr_o <= w_addr;
                  gnt0_o     <= (w_win == ARB_PORT_CPU);
                  gnt1_o     <= (w_win == ARB_PORT_DBG);
                  rom_ce_o   <= w_ce_on_grant;
                  r_cnt      <= '0;
                  busy_o     <= 1'b1;
                  r_state    <= ARB_ACCESS;
`ifdef ROM_ARB_ALIGN_CHECK_EN
                  r_misal    <= w_misal;
`endif
               end else begin
                  busy_o  <= 1'b0;
                  r_state <= ARB_IDLE;
               end
            end
            ARB_ACCESS: begin
`ifdef ROM_ARB_ALIGN_CHECK_EN
               // Misaligned grant: skip the ROM, answer with zero data and an error.
               if (r_misal) begin
                  r_misal   <= 1'b0;
                  rdata_o   <= '0;
                  err_o     <= 1'b1;
                  rvalid0_o <= (r_sel == ARB_PORT_CPU);
                  rvalid1_o <= (r_sel == ARB_PORT_DBG);
                  r_cnt     <= '0;
                  r_state   <= ARB_RESP;
               end else
`endif
               if (r_cnt == CNT_LAST) begin
                  rdata_o   <= rom_data_i;
                  rom_ce_o  <= 1'b0;
                  rvalid0_o <= (r_sel == ARB_PORT_CPU);
                  rvalid1_o <= (r_sel == ARB_PORT_DBG);
                  r_cnt     <= '0;
                  r_state   <= ARB_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               rom_ce_o <= 1'b0;
               busy_o   <= 1'b0;
               r_state  <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
